// File: rtl/operand_feeder.sv
// Operand-pair FIFO feeding a multi-cycle multiplier core through an IDLE/ISSUE/WAIT handshake.
// Optional zero-operand bypass: define OPERAND_FEEDER_ZERO_SKIP_EN.
module operand_feeder #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_a,
   input  logic [N-1:0]             in_b,
   output logic                     core_start,
   output logic [N-1:0]             core_a,
   output logic [N-1:0]             core_b,
   input  logic                     core_done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     zero_skip
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   mem_a [DEPTH];
   logic [N-1:0]   mem_b [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           push;
   logic           pop;
   logic           load;
   logic [N-1:0]   head_a;
   logic [N-1:0]   head_b;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign level      = wr_ptr - rd_ptr;
   assign in_ready   = ~level[AW];
   assign push       = in_valid & in_ready;
   assign head_a     = mem_a[rd_ptr[AW-1:0]];
   assign head_b     = mem_b[rd_ptr[AW-1:0]];
   assign core_start = (state == ISSUE);
   assign busy       = (state != IDLE);

`ifdef OPERAND_FEEDER_ZERO_SKIP_EN
   logic skip;
   logic zs_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         zs_q <= 1'b0;
      end else begin
         zs_q <= skip;
      end
   end

   assign zero_skip = zs_q;
`else
   assign zero_skip = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      load      = 1'b0;
`ifdef OPERAND_FEEDER_ZERO_SKIP_EN
      skip      = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (level != '0) begin
               pop = 1'b1;
`ifdef OPERAND_FEEDER_ZERO_SKIP_EN
               if (head_a == '0 || head_b == '0) begin
                  skip = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = ISSUE;
               end
`else
               load      = 1'b1;
               state_nxt = ISSUE;
`endif
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (core_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         core_a <= '0;
         core_b <= '0;
      end else begin
         state <= state_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         if (load) begin
            core_a <= head_a;
            core_b <= head_b;
         end
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr[AW-1:0]] <= in_a;
         mem_b[wr_ptr[AW-1:0]] <= in_b;
      end
   end

endmodule
